// File: rtl/dmem_arbiter_if.sv
// Bundle of requester-side and memory-side signals for the two-port data-memory arbiter.
// The arbiter attaches through the slave modport; the requesters and the memory model use master.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              r0_req;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [1:0]        r0_len;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_gnt;
  logic              r0_beat;
  logic              r0_rvalid;
  logic [DATA_W-1:0] r0_rdata;

  logic              r1_req;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [1:0]        r1_len;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_gnt;
  logic              r1_beat;
  logic              r1_rvalid;
  logic [DATA_W-1:0] r1_rdata;

  logic              busy;
  logic              mem_write;
  logic              mem_read;
  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_len, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_len, r1_wdata,
    input  mem_rdata,
    output r0_gnt, r0_beat, r0_rvalid, r0_rdata,
    output r1_gnt, r1_beat, r1_rvalid, r1_rdata,
    output busy, mem_write, mem_read, mem_addr, mem_wdata
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_len, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_len, r1_wdata,
    output mem_rdata,
    input  r0_gnt, r0_beat, r0_rvalid, r0_rdata,
    input  r1_gnt, r1_beat, r1_rvalid, r1_rdata,
    input  busy, mem_write, mem_read, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and 1-4 beat burst sequencer sharing one single-ported data memory
// between the core load/store port (requester 0) and the debug/DMA port (requester 1).
module dmem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input logic         clk,
  input logic         rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic              owner, owner_nxt;
  logic              last_owner, last_owner_nxt;
  logic              we_q, we_nxt;
  logic [ADDR_W-1:0] base_q, base_nxt;
  logic [1:0]        cnt, cnt_nxt;
  logic [1:0]        len_q, len_nxt;

  logic              any_req;
  logic              winner;
  logic              busy_int;
  logic              write_int;
  logic              read_int;
  logic [ADDR_W-1:0] beat_addr;

  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    any_req = bus.r0_req | bus.r1_req;
    winner  = 1'b0;
    if (bus.r0_req && bus.r1_req) begin
      winner = ~last_owner;
    end else if (bus.r1_req) begin
      winner = 1'b1;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    we_nxt         = we_q;
    base_nxt       = base_q;
    cnt_nxt        = cnt;
    len_nxt        = len_q;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt      = BURST;
          owner_nxt      = winner;
          last_owner_nxt = winner;
          cnt_nxt        = 2'd0;
          base_nxt       = winner ? bus.r1_addr : bus.r0_addr;
          we_nxt         = winner ? bus.r1_we   : bus.r0_we;
          len_nxt        = winner ? bus.r1_len  : bus.r0_len;
        end
      end
      BURST: begin
        if (cnt == len_q) begin
          state_nxt = IDLE;
          cnt_nxt   = 2'd0;
        end else begin
          cnt_nxt = cnt + 2'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      we_q       <= 1'b0;
      base_q     <= '0;
      cnt        <= 2'd0;
      len_q      <= 2'd0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      we_q       <= we_nxt;
      base_q     <= base_nxt;
      cnt        <= cnt_nxt;
      len_q      <= len_nxt;
    end
  end

  // Beat addresses wrap naturally at the ADDR_W-bit boundary.
  assign busy_int  = (state == BURST);
  assign write_int = busy_int & we_q;
  assign read_int  = busy_int & ~we_q;
  assign beat_addr = base_q + ADDR_W'(cnt);

  assign bus.busy      = busy_int;
  assign bus.r0_beat   = busy_int & ~owner;
  assign bus.r1_beat   = busy_int & owner;
  assign bus.r0_gnt    = busy_int & ~owner & (cnt == 2'd0);
  assign bus.r1_gnt    = busy_int & owner & (cnt == 2'd0);
  assign bus.mem_write = write_int;
  assign bus.mem_read  = read_int;
  assign bus.mem_addr  = busy_int ? {{(32-ADDR_W){1'b0}}, beat_addr} : 32'd0;
  assign bus.mem_wdata = write_int ? (owner ? bus.r1_wdata : bus.r0_wdata) : '0;

  // Read data lands in the owner's register; the other port keeps its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= read_int & ~owner;
      rvalid1_q <= read_int & owner;
      if (read_int && !owner) begin
        rdata0_q <= bus.mem_rdata;
      end
      if (read_int && owner) begin
        rdata1_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.r0_rvalid = rvalid0_q;
  assign bus.r1_rvalid = rvalid1_q;
  assign bus.r0_rdata  = rdata0_q;
  assign bus.r1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic, every cycle compared
// against a transaction-queue model of the burst schedule.
module tb_dmem_arbiter;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Memory behind the arbiter: combinational read, write on the beat edge.
  logic [31:0] mem [0:63];
  logic        mem_init;
  logic        pre_en;
  logic [5:0]  pre_addr;
  logic [31:0] pre_data;

  assign bus.mem_rdata = mem[bus.mem_addr[5:0]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h5000_0000 + 32'(i);
    end else if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (bus.mem_write) begin
      mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
    end
  end

  // Each slot describes one cycle of the schedule: a beat or an idle cycle.
  typedef struct packed {
    logic       idle;
    logic       own;
    logic       we;
    logic [5:0] addr;
    logic       first;
  } slot_t;

  slot_t       plan[$];
  slot_t       cur;
  logic        last_win;
  logic [1:0]  exp_rvalid;
  logic [31:0] exp_rdata [0:1];

  int checks = 0;
  int errors = 0;

  function automatic slot_t idle_slot();
    slot_t s;
    s      = '0;
    s.idle = 1'b1;
    return s;
  endfunction

  task automatic modelReset();
    plan.delete();
    cur          = idle_slot();
    last_win     = 1'b1;
    exp_rvalid   = 2'b00;
    exp_rdata[0] = 32'd0;
    exp_rdata[1] = 32'd0;
  endtask

  // Decide what the cycle after the coming edge looks like.
  task automatic modelAdvance();
    logic [1:0] nv;
    logic       win;
    logic       w;
    logic [5:0] b;
    int         n;
    slot_t      s;
    nv = 2'b00;
    if (!cur.idle && !cur.we) begin
      nv[cur.own]        = 1'b1;
      exp_rdata[cur.own] = mem[cur.addr];
    end
    exp_rvalid = nv;
    if (cur.idle && plan.size() == 0 && (bus.r0_req || bus.r1_req)) begin
      if (bus.r0_req && bus.r1_req) win = !last_win;
      else win = bus.r1_req;
      last_win = win;
      b = win ? bus.r1_addr : bus.r0_addr;
      w = win ? bus.r1_we : bus.r0_we;
      n = int'(win ? bus.r1_len : bus.r0_len) + 1;
      for (int i = 0; i < n; i++) begin
        s       = '0;
        s.own   = win;
        s.we    = w;
        s.addr  = b + 6'(i);
        s.first = (i == 0);
        plan.push_back(s);
      end
      plan.push_back(idle_slot());
    end
    if (plan.size() > 0) cur = plan.pop_front();
    else cur = idle_slot();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic        act;
    logic [31:0] wd;
    act = !cur.idle;
    wd  = (act && cur.we) ? (cur.own ? bus.r1_wdata : bus.r0_wdata) : 32'd0;
    chk("r0_gnt", 32'(bus.r0_gnt), 32'(act && !cur.own && cur.first));
    chk("r1_gnt", 32'(bus.r1_gnt), 32'(act && cur.own && cur.first));
    chk("r0_beat", 32'(bus.r0_beat), 32'(act && !cur.own));
    chk("r1_beat", 32'(bus.r1_beat), 32'(act && cur.own));
    chk("busy", 32'(bus.busy), 32'(act));
    chk("mem_write", 32'(bus.mem_write), 32'(act && cur.we));
    chk("mem_read", 32'(bus.mem_read), 32'(act && !cur.we));
    chk("strobe_excl", 32'(bus.mem_write & bus.mem_read), 32'd0);
    chk("mem_addr", bus.mem_addr, act ? 32'(cur.addr) : 32'd0);
    chk("mem_wdata", bus.mem_wdata, wd);
    chk("r0_rvalid", 32'(bus.r0_rvalid), 32'(exp_rvalid[0]));
    chk("r1_rvalid", 32'(bus.r1_rvalid), 32'(exp_rvalid[1]));
    chk("r0_rdata", bus.r0_rdata, exp_rdata[0]);
    chk("r1_rdata", bus.r1_rdata, exp_rdata[1]);
  endtask

  task automatic applyStimulus(input int port, input logic req, input logic we,
                               input logic [5:0] addr, input logic [1:0] len,
                               input logic [31:0] wdata);
    if (port == 0) begin
      bus.r0_req = req; bus.r0_we = we; bus.r0_addr = addr;
      bus.r0_len = len; bus.r0_wdata = wdata;
    end else begin
      bus.r1_req = req; bus.r1_we = we; bus.r1_addr = addr;
      bus.r1_len = len; bus.r1_wdata = wdata;
    end
  endtask

  task automatic tick();
    modelAdvance();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    #1;
    checkOutput();
    tick();
  endtask

  task automatic applyReset();
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput();
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_en = 1'b0;
  endtask

  // Requesters hold req until their grant, then either drop it or ask again.
  task automatic randReq(input int k);
    logic        r;
    logic [31:0] wd;
    wd = $urandom();
    r  = (k == 0) ? bus.r0_req : bus.r1_req;
    if (!r) begin
      if ($urandom_range(0, 2) == 0)
        applyStimulus(k, 1'b1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                      2'($urandom_range(0, 3)), wd);
      else if (k == 0) bus.r0_wdata = wd;
      else bus.r1_wdata = wd;
    end else if (!cur.idle && cur.first && int'(cur.own) == k) begin
      applyStimulus(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)), wd);
    end else if (k == 0) bus.r0_wdata = wd;
    else bus.r1_wdata = wd;
  endtask

  initial begin
    rst      = 1'b1;
    mem_init = 1'b1;
    pre_en   = 1'b0;
    pre_addr = 6'd0;
    pre_data = 32'd0;
    applyStimulus(0, 1'b0, 1'b0, 6'd0, 2'd0, 32'd0);
    applyStimulus(1, 1'b0, 1'b0, 6'd0, 2'd0, 32'd0);
    modelReset();
    @(posedge clk);
    #1;
    mem_init = 1'b0;
    checkOutput();
    rst = 1'b0;
    step();
    step();

    $display("[TB] reset pulse while idle, then single-beat read");
    applyReset();
    applyStimulus(0, 1'b1, 1'b0, 6'd5, 2'd0, 32'd0);
    step();
    applyStimulus(0, 1'b0, 1'b0, 6'd5, 2'd0, 32'd0);
    repeat (3) step();

    $display("[TB] simultaneous requests alternate");
    applyStimulus(0, 1'b1, 1'b0, 6'd7, 2'd1, 32'd0);
    applyStimulus(1, 1'b1, 1'b0, 6'd40, 2'd0, 32'd0);
    repeat (14) step();
    applyStimulus(0, 1'b0, 1'b0, 6'd0, 2'd0, 32'd0);
    applyStimulus(1, 1'b0, 1'b0, 6'd0, 2'd0, 32'd0);
    repeat (4) step();

    $display("[TB] wrapping write burst on port 1");
    applyStimulus(1, 1'b1, 1'b1, 6'd62, 2'd3, 32'hDEAD_0000);
    step();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1'b0, 1'b1, 6'd62, 2'd3, 32'hDEAD_0010 + 32'(i));
      step();
    end
    step();

    $display("[TB] read burst with req toggling, then read back the wrapped write");
    preload(6'd10, 32'h0000_000A);
    preload(6'd11, 32'h0000_000B);
    preload(6'd12, 32'h0000_000C);
    applyStimulus(0, 1'b1, 1'b0, 6'd10, 2'd2, 32'd0);
    step();
    applyStimulus(0, 1'b0, 1'b0, 6'd10, 2'd2, 32'd0);
    step();
    applyStimulus(0, 1'b1, 1'b1, 6'd33, 2'd3, 32'd0);
    step();
    applyStimulus(0, 1'b0, 1'b0, 6'd10, 2'd2, 32'd0);
    repeat (3) step();
    applyStimulus(0, 1'b1, 1'b0, 6'd62, 2'd3, 32'd0);
    step();
    applyStimulus(0, 1'b0, 1'b0, 6'd62, 2'd3, 32'd0);
    repeat (6) step();

    $display("[TB] reset during the second beat of a write burst");
    applyStimulus(0, 1'b1, 1'b1, 6'd20, 2'd3, 32'h1111_0000);
    step();
    applyStimulus(0, 1'b0, 1'b1, 6'd20, 2'd3, 32'h1111_0001);
    step();
    applyStimulus(0, 1'b0, 1'b1, 6'd20, 2'd3, 32'h1111_0002);
    applyReset();
    repeat (5) step();

    $display("[TB] random interleaved traffic");
    for (int c = 0; c < 600; c++) begin
      randReq(0);
      randReq(1);
      step();
    end
    applyStimulus(0, 1'b0, 1'b0, 6'd0, 2'd0, 32'd0);
    applyStimulus(1, 1'b0, 1'b0, 6'd0, 2'd0, 32'd0);
    repeat (8) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and burst sequencer in front of the single-ported 64-word data memory. It shares the memory between the core load/store port (requester 0) and the debug/DMA port (requester 1) using round-robin arbitration. It sequences 1–4 word bursts with auto-incrementing, wrapping addresses, and returns read data registered one cycle after each beat. It drives the memory's write/read strobes, address and write data, and samples the memory's combinational read output.

## Interface
- ADDR_W, 6, word-address width; memory depth is 2^ADDR_W words
- DATA_W, 32, data width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- r0_req / r1_req  in  1  burst request; held high until the matching gnt
- r0_we / r1_we  in  1  1 = write burst, 0 = read burst; stable while req is high
- r0_addr / r1_addr  in  ADDR_W  burst base word address; stable while req is high
- r0_len / r1_len  in  2  beats minus one (0 → 1 beat, 3 → 4 beats)
- r0_wdata / r1_wdata  in  DATA_W  write data, sampled in each beat cycle of the owner
- r0_gnt / r1_gnt  out  1  one-cycle pulse in the first beat cycle of a granted burst
- r0_beat / r1_beat  out  1  high in every beat cycle of that requester's burst
- r0_rvalid / r1_rvalid  out  1  read data valid, one cycle after each read beat
- r0_rdata / r1_rdata  out  DATA_W  registered read data
- busy  out  1  high while a burst is in progress (state BURST)
- mem_write / mem_read  out  1  memory strobes
- mem_addr  out  32  word index; upper 32−ADDR_W bits are always 0
- mem_wdata  out  DATA_W  write data to memory
- mem_rdata  in  DATA_W  combinational read data from memory

## Operation
- **States.** IDLE and BURST. Registers:
  - owner (1 bit)
  - last_owner (reset 1, so requester 0 wins the first tie)
  - base address (ADDR_W bits)
  - we
  - beat counter cnt (2 bits)
  - len (2 bits)
- **IDLE.**
  - No request: stay in IDLE.
  - One requester high: select it.
  - Both high: select !last_owner.
  - On selection, at the clock edge latch owner, addr, we and len; set cnt = 0 and last_owner = winner; go to BURST.
- **BURST, each cycle:**
  - beat output of the owner is high.
  - mem_addr = zero-extend((base + cnt) mod 2^ADDR_W).
  - mem_write = we; mem_read = !we.
  - mem_wdata = owner's wdata when we = 1, else 0.
  - If cnt == len, go to IDLE; otherwise cnt increments.
- **gnt.** The owner's gnt is high only when cnt == 0 in BURST.
- **Read return.** On a read beat, mem_rdata is registered into the owner's rdata, and the owner's rvalid is high in the following cycle. The other requester's rdata holds its last value; its rvalid stays 0.
- **Address wrap.** The address wraps: base 62 with len 3 accesses 62, 63, 0, 1.
- **Requests sampled only in IDLE.**
  - req/addr/len/we changes during BURST are ignored.
  - A requester that holds req high after its gnt starts a new burst at the next arbitration.
- **Non-owner outputs.** In BURST the non-owner's gnt and beat are 0, and it may not be served until the next IDLE.
- **Strobe exclusivity.** mem_write and mem_read are never high together. Both are 0 in IDLE, and mem_addr and mem_wdata are 0 there.

## Timing
- **Reset values.** On rst assertion, immediately and asynchronously:
  - state = IDLE, cnt = 0, last_owner = 1
  - all gnt, beat, rvalid, busy and mem strobes = 0
  - all rdata = 0, mem_addr = 0, mem_wdata = 0
- **Reset mid-burst.** The burst is aborted. No further strobes are issued, and pending rvalid is dropped. After rst deasserts, the first rising edge performs arbitration normally.
- **Burst timing.** A request sampled high in IDLE at edge E gives beats in cycles E+1 … E+len+1; gnt is in cycle E+1. Read rvalid appears in cycles E+2 … E+len+2.
- **Back-to-back bursts.** After the last beat the block spends one cycle in IDLE before the next burst. Back-to-back bursts therefore have a one-cycle bubble.
- **rvalid overlap.** The last read rvalid of one burst coincides with that IDLE cycle.
- **Write latency.** Writes complete at the memory on the beat cycle's edge. There is no write acknowledge beyond beat.
- **Worst-case wait.** A requester waits at most one competing burst (≤ 4 beats + 1 IDLE cycle) before its grant.

## Test plan
- **Reset.** rst pulse mid-cycle while idle → all outputs 0 immediately; then r0_req = 1 alone, read, addr 5, len 0 → r0_gnt = r0_beat = 1, mem_read = 1, mem_addr = 5 one cycle later; r0_rvalid with mem_rdata the cycle after.
- **Tie after reset.** Both requesting after reset → r0 granted first; r1 granted after r0's burst plus one IDLE cycle; with both still requesting, grants alternate 0, 1, 0, 1.
- **Write burst with wrap.** r1 write, addr 62, len 3, wdata changed each beat → mem_write high 4 cycles with mem_addr 62, 63, 0, 1 and matching wdata; r1_gnt high only on the first beat.
- **Read burst, stable inputs.** r0 read, len 2, memory preloaded with 0xA, 0xB, 0xC at 10..12 → r0_rvalid high 3 consecutive cycles with rdata 0xA, 0xB, 0xC; r0_req toggled during the burst has no effect.
- **Reset mid-burst.** rst asserted during beat 2 of a 4-beat write → mem_write drops the same instant; busy = 0; no beats 3 or 4 after release.
- **Strobe invariants.** Random interleaved bursts → mem_write & mem_read never both 1; every beat address equals (base + index) mod 64.
